// File: rtl/btb_pkg.sv
// Shared types for the BTB update controller: op encodings, queued-op record, FSM states.
package btb_pkg;

  localparam int unsigned BTB_ADDR_LEN = 12;

  typedef enum logic [1:0] {
    BTB_NOP = 2'b00,
    BTB_UPD = 2'b01,
    BTB_ADD = 2'b10,
    BTB_INV = 2'b11
  } btb_op_e;

  typedef struct packed {
    btb_op_e     op;
    logic [31:0] pc;
    logic [31:0] target;
  } btb_upd_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } ctrl_state_e;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// EX branch-resolution bundle plus BTB write port; master = EX/BTB side, slave = controller.
interface btb_update_ctrl_if;

  logic        ex_br;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_hit;
  logic [31:0] ex_pred_target;
  logic        ex_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  web;
  logic [31:0] waddr;
  logic [31:0] wr_data;

  modport master (
    output ex_br, ex_pc, ex_taken, ex_target, ex_pred_hit, ex_pred_target,
    input  ex_stall, redirect, redirect_pc, web, waddr, wr_data
  );

  modport slave (
    input  ex_br, ex_pc, ex_taken, ex_target, ex_pred_hit, ex_pred_target,
    output ex_stall, redirect, redirect_pc, web, waddr, wr_data
  );

endinterface

// File: rtl/btb_upd_fifo.sv
// Small FIFO of pending BTB ops; push and pop may coincide even when full.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  logic     clear,
  input  btb_upd_t din,
  output btb_upd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  btb_upd_t        mem [FIFO_DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [PW:0]     cnt;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    full    = (cnt == (PW+1)'(FIFO_DEPTH));
    empty   = (cnt == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout    = mem[rp];
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: classifies EX branches, keeps a 2-bit BHT, queues ops, sweeps on flush.
// Optional BTB_CTRL_PERF_EN adds branch / redirect counters.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned BTB_ADDR_LEN = btb_pkg::BTB_ADDR_LEN,
  parameter int unsigned BHT_ADDR_LEN = 6,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_req,
  output logic               sweep_busy,
`ifdef BTB_CTRL_PERF_EN
  output logic [31:0]        perf_br_cnt,
  output logic [31:0]        perf_miss_cnt,
`endif
  btb_update_ctrl_if.slave   bif
);

  localparam int unsigned BHT_SIZE = 1 << BHT_ADDR_LEN;

  ctrl_state_e             state;
  logic [1:0]              bht [BHT_SIZE];
  logic [BTB_ADDR_LEN-1:0] idx;
  logic [BHT_ADDR_LEN-1:0] bht_idx;
  logic [1:0]              cnt;
  logic [1:0]              cnt_nxt;
  logic                    push_needed;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    accept;
  btb_upd_t                push_op;
  btb_upd_t                head;

  always_comb begin
    bht_idx = bif.ex_pc[BHT_ADDR_LEN+1:2];
    cnt     = bht[bht_idx];
    if (bif.ex_taken) cnt_nxt = (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else              cnt_nxt = (cnt == 2'b00) ? cnt : cnt - 2'd1;

    push_needed    = 1'b0;
    push_op.op     = BTB_NOP;
    push_op.pc     = bif.ex_pc;
    push_op.target = bif.ex_target;
    bif.redirect   = 1'b0;
    bif.redirect_pc = bif.ex_taken ? bif.ex_target : bif.ex_pc + 32'd4;
    if (bif.ex_br) begin
      if (bif.ex_taken) begin
        if (!bif.ex_pred_hit) begin
          push_needed  = 1'b1;
          push_op.op   = BTB_ADD;
          bif.redirect = 1'b1;
        end else if (bif.ex_target != bif.ex_pred_target) begin
          push_needed  = 1'b1;
          push_op.op   = BTB_UPD;
          bif.redirect = 1'b1;
        end
      end else if (bif.ex_pred_hit) begin
        bif.redirect = 1'b1;
        if (cnt_nxt <= 2'b01) begin
          push_needed    = 1'b1;
          push_op.op     = BTB_INV;
          push_op.target = '0;
        end
      end
    end

    // A flush discards this cycle's head and branch; the sweep owns the write port.
    fifo_pop     = (state == IDLE) & ~fifo_empty & ~flush_req;
    bif.ex_stall = fifo_full & push_needed & ~fifo_pop;
    accept       = bif.ex_br & ~bif.ex_stall & ~flush_req;
    fifo_push    = accept & push_needed;
  end

  btb_upd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush_req),
    .din   (push_op),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Flush issues INV for index 0 immediately, so the sweep continues from idx=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      sweep_busy  <= 1'b0;
      bif.web     <= BTB_NOP;
      bif.waddr   <= '0;
      bif.wr_data <= '0;
      for (int unsigned i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (flush_req) begin
      state       <= SWEEP;
      idx         <= BTB_ADDR_LEN'(1);
      sweep_busy  <= 1'b1;
      bif.web     <= BTB_INV;
      bif.waddr   <= '0;
      bif.wr_data <= '0;
      for (int unsigned i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else begin
      if (accept) bht[bht_idx] <= cnt_nxt;
      case (state)
        IDLE: begin
          sweep_busy <= 1'b0;
          if (fifo_pop) begin
            bif.web     <= head.op;
            bif.waddr   <= head.pc;
            bif.wr_data <= head.target;
          end else begin
            bif.web     <= BTB_NOP;
          end
        end
        SWEEP: begin
          sweep_busy  <= 1'b1;
          bif.web     <= BTB_INV;
          bif.waddr   <= 32'(idx);
          bif.wr_data <= '0;
          idx         <= idx + BTB_ADDR_LEN'(1);
          if (idx == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BTB_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_cnt   <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (accept) perf_br_cnt <= perf_br_cnt + 32'd1;
      if (bif.redirect && !bif.ex_stall) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
